// File: rtl/param_register_file.sv
// Parametrised 2-read/1-write register file with registered, write-first forwarding reads.
// Optional macro ZERO_REG_EN: entry 0 is hardwired to zero.
module param_register_file #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 2
) (
    input  logic              input_Clock,
    input  logic              input_Reset,
    input  logic              input_Read_En,
    input  logic              input_Write_En,
    input  logic [ADDR_W-1:0] input_Read_Register1,
    input  logic [ADDR_W-1:0] input_Read_Register2,
    input  logic [ADDR_W-1:0] input_Write_Register,
    input  logic [DATA_W-1:0] input_Write_Data,
    output logic [DATA_W-1:0] output_Read_Data1,
    output logic [DATA_W-1:0] output_Read_Data2,
    output logic              output_Read_Valid,
    output logic [DATA_W-1:0] output_Output,
    output logic [7:0]        output_Write_Count
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] entries [DEPTH];
    logic              entry_we;
    logic [DATA_W-1:0] rd1_next;
    logic [DATA_W-1:0] rd2_next;

    // Storage update is separated from the accepted-write bookkeeping so the
    // zero register can discard data while still counting the write.
    always_comb begin
        entry_we = input_Write_En;
`ifdef ZERO_REG_EN
        if (input_Write_Register == '0) begin
            entry_we = 1'b0;
        end
`endif
    end

    always_comb begin
        rd1_next = entries[input_Read_Register1];
        rd2_next = entries[input_Read_Register2];
        if (entry_we && (input_Write_Register == input_Read_Register1)) begin
            rd1_next = input_Write_Data;
        end
        if (entry_we && (input_Write_Register == input_Read_Register2)) begin
            rd2_next = input_Write_Data;
        end
`ifdef ZERO_REG_EN
        if (input_Read_Register1 == '0) begin
            rd1_next = '0;
        end
        if (input_Read_Register2 == '0) begin
            rd2_next = '0;
        end
`endif
    end

    always_ff @(posedge input_Clock) begin
        if (input_Reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                entries[i] <= '0;
            end
            output_Read_Data1  <= '0;
            output_Read_Data2  <= '0;
            output_Read_Valid  <= 1'b0;
            output_Output      <= '0;
            output_Write_Count <= '0;
        end else begin
            if (entry_we) begin
                entries[input_Write_Register] <= input_Write_Data;
            end
            if (input_Write_En) begin
                output_Output <= input_Write_Data;
                if (output_Write_Count != 8'hFF) begin
                    output_Write_Count <= output_Write_Count + 8'd1;
                end
            end
            output_Read_Valid <= input_Read_En;
            if (input_Read_En) begin
                output_Read_Data1 <= rd1_next;
                output_Read_Data2 <= rd2_next;
            end
        end
    end

endmodule

// File: tb/tb_param_register_file.sv
// Scoreboard bench for param_register_file: read expectations are queued at issue
// and checked by a monitor whenever the read-valid strobe is seen.
module tb_param_register_file;

    logic       clk;
    logic       rst;
    logic       re;
    logic       we;
    logic [1:0] rr1;
    logic [1:0] rr2;
    logic [1:0] wr;
    logic [7:0] wd;
    logic [7:0] rd1;
    logic [7:0] rd2;
    logic       rvalid;
    logic [7:0] wout;
    logic [7:0] wcount;

    int checks = 0;
    int errors = 0;
    logic [15:0] exp_q [$];

    param_register_file #(.DATA_W(8), .ADDR_W(2)) dut (
        .input_Clock          (clk),
        .input_Reset          (rst),
        .input_Read_En        (re),
        .input_Write_En       (we),
        .input_Read_Register1 (rr1),
        .input_Read_Register2 (rr2),
        .input_Write_Register (wr),
        .input_Write_Data     (wd),
        .output_Read_Data1    (rd1),
        .output_Read_Data2    (rd2),
        .output_Read_Valid    (rvalid),
        .output_Output        (wout),
        .output_Write_Count   (wcount)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Monitor: every valid pulse must match the oldest outstanding read.
    always @(negedge clk) begin
        if (rvalid === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_valid: got valid=1 expected no read outstanding");
            end else begin
                logic [15:0] e;
                e = exp_q.pop_front();
                check("read_data1", rd1, e[15:8]);
                check("read_data2", rd2, e[7:0]);
            end
        end
    end

    // One clock edge with the given inputs; inputs return to idle right after.
    task automatic step(input logic r, input logic rd_en, input logic wr_en,
                        input logic [1:0] a1, input logic [1:0] a2,
                        input logic [1:0] wa, input logic [7:0] wdat,
                        input logic [7:0] e1, input logic [7:0] e2);
        rst = r; re = rd_en; we = wr_en;
        rr1 = a1; rr2 = a2; wr = wa; wd = wdat;
        if (rd_en && !r) exp_q.push_back({e1, e2});
        @(posedge clk);
        #1;
        rst = 1'b0; re = 1'b0; we = 1'b0;
    endtask

    task automatic wr_only(input logic [1:0] wa, input logic [7:0] wdat);
        step(1'b0, 1'b0, 1'b1, 2'd0, 2'd0, wa, wdat, 8'h00, 8'h00);
    endtask

    task automatic rd_only(input logic [1:0] a1, input logic [1:0] a2,
                           input logic [7:0] e1, input logic [7:0] e2);
        step(1'b0, 1'b1, 1'b0, a1, a2, 2'd0, 8'h00, e1, e2);
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0, 8'h00, 8'h00, 8'h00);
    endtask

    initial begin
        logic [7:0] zero_exp;
        rst = 1'b0; re = 1'b0; we = 1'b0;
        rr1 = '0; rr2 = '0; wr = '0; wd = '0;
        @(negedge clk);

        // Reset state
        step(1'b1, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0, 8'h00, 8'h00, 8'h00);
        step(1'b1, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0, 8'h00, 8'h00, 8'h00);
        check("rst_data1", rd1, 8'h00);
        check("rst_data2", rd2, 8'h00);
        check("rst_valid", {7'd0, rvalid}, 8'h00);
        check("rst_output", wout, 8'h00);
        check("rst_count", wcount, 8'h00);

        // Read of freshly reset entries, then hold with Read_En low
        rd_only(2'd1, 2'd2, 8'h00, 8'h00);
        check("read_valid_hi", {7'd0, rvalid}, 8'h01);
        idle();
        check("idle_valid_lo", {7'd0, rvalid}, 8'h00);
        check("idle_hold1", rd1, 8'h00);

        // Plain writes then read
        wr_only(2'd3, 8'hA5);
        wr_only(2'd1, 8'h3C);
        rd_only(2'd3, 2'd1, 8'hA5, 8'h3C);
        check("wr_output", wout, 8'h3C);
        check("wr_count", wcount, 8'd2);
        idle();
        check("hold_data1", rd1, 8'hA5);
        check("hold_data2", rd2, 8'h3C);

        // Forwarding on both ports, then a later read of the same entry
        step(1'b0, 1'b1, 1'b1, 2'd2, 2'd2, 2'd2, 8'h77, 8'h77, 8'h77);
        rd_only(2'd2, 2'd0, 8'h77, 8'h00);
        // Back-to-back reads keep valid high
        rd_only(2'd3, 2'd2, 8'hA5, 8'h77);
        check("b2b_valid", {7'd0, rvalid}, 8'h01);
        rd_only(2'd1, 2'd3, 8'h3C, 8'hA5);
        check("b2b_valid2", {7'd0, rvalid}, 8'h01);
        // Forwarding on port 2 only
        step(1'b0, 1'b1, 1'b1, 2'd3, 2'd1, 2'd1, 8'h11, 8'hA5, 8'h11);
        check("fwd_output", wout, 8'h11);
        check("fwd_count", wcount, 8'd4);

        // Address 0 write with simultaneous read
`ifdef ZERO_REG_EN
        zero_exp = 8'h00;
`else
        zero_exp = 8'h5A;
`endif
        step(1'b0, 1'b1, 1'b1, 2'd0, 2'd0, 2'd0, 8'h5A, zero_exp, zero_exp);
        check("zero_output", wout, 8'h5A);
        check("zero_count", wcount, 8'd5);
        rd_only(2'd0, 2'd1, zero_exp, 8'h11);

        // Write count saturation: 5 + 250 = 255
        for (int i = 0; i < 260; i++) begin
            wr_only(2'd2, 8'(i));
            if (i == 248) check("sat_254", wcount, 8'd254);
            if (i == 249) check("sat_255", wcount, 8'd255);
        end
        check("sat_hold", wcount, 8'd255);
        check("sat_last_output", wout, 8'h03);
        wr_only(2'd2, 8'hC4);
        check("sat_extra", wcount, 8'd255);
        rd_only(2'd2, 2'd3, 8'hC4, 8'hA5);

        // Reset wins over a read in the same cycle
        wr_only(2'd1, 8'hFF);
        step(1'b1, 1'b1, 1'b0, 2'd1, 2'd1, 2'd0, 8'h00, 8'h00, 8'h00);
        check("rstrd_valid", {7'd0, rvalid}, 8'h00);
        check("rstrd_data1", rd1, 8'h00);
        check("rstrd_data2", rd2, 8'h00);
        check("rstrd_output", wout, 8'h00);
        check("rstrd_count", wcount, 8'h00);
        rd_only(2'd1, 2'd3, 8'h00, 8'h00);

        idle();
        idle();
        check("queue_drained", 8'(exp_q.size()), 8'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
